// File: rtl/uart_hex_display_ctrl.sv
// uart_hex_display_ctrl
// Turns lines of ASCII hex characters from a UART receiver into a committed
// display value and scans that value out one digit at a time.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   rx_data/rx_valid received byte and its one-cycle strobe (no backpressure)
//   conv_ascii      byte handed to the external ASCII-to-nibble converter
//   conv_nibble     converter result for conv_ascii (same cycle)
//   digit_val       committed value, digit 0 in bits [3:0]
//   commit          one-cycle pulse when digit_val is updated
//   err             one-cycle pulse on the first invalid character of a line
//   scan_sel        one-hot active-high digit enable
//   scan_nibble     nibble of digit_val for the enabled digit
module uart_hex_display_ctrl #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic [7:0]              conv_ascii,
    input  logic [3:0]              conv_nibble,
    output logic [4*NUM_DIGITS-1:0] digit_val,
    output logic                    commit,
    output logic                    err,
    output logic [NUM_DIGITS-1:0]   scan_sel,
    output logic [3:0]              scan_nibble
);

    localparam int unsigned VAL_W = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W = $clog2(NUM_DIGITS + 1);
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned PRE_W = $clog2(SCAN_DIV);

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_ERROR   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [VAL_W-1:0]   shadow_q, shadow_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [VAL_W-1:0]   digit_val_q, digit_val_d;
    logic               commit_q, commit_d;
    logic               err_q, err_d;
    logic [PRE_W-1:0]   presc_q, presc_d;
    logic [IDX_W-1:0]   index_q, index_d;

    logic               is_hex_c;

    // The converter sees the raw byte at all times
    assign conv_ascii = rx_data;

    // Uppercase hex only; lowercase falls through to the error path
    assign is_hex_c = ((rx_data >= 8'h30) && (rx_data <= 8'h39)) ||
                      ((rx_data >= 8'h41) && (rx_data <= 8'h46));

    // Line parser next-state and outputs
    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        count_d     = count_q;
        digit_val_d = digit_val_q;
        commit_d    = 1'b0;
        err_d       = 1'b0;

        if (rx_valid && (rx_data != CHAR_LF)) begin
            case (state_q)
                ST_IDLE, ST_COLLECT: begin
                    if (is_hex_c) begin
                        // Shifting left drops the oldest digit once full
                        shadow_d = (shadow_q << 4) | VAL_W'(conv_nibble);
                        if (count_q != CNT_W'(NUM_DIGITS)) begin
                            count_d = count_q + CNT_W'(1);
                        end
                        state_d = ST_COLLECT;
                    end else if (rx_data == CHAR_CR) begin
                        if (state_q == ST_COLLECT) begin
                            digit_val_d = shadow_q;
                            commit_d    = 1'b1;
                        end
                        shadow_d = '0;
                        count_d  = '0;
                        state_d  = ST_IDLE;
                    end else begin
                        err_d    = 1'b1;
                        shadow_d = '0;
                        count_d  = '0;
                        state_d  = ST_ERROR;
                    end
                end
                ST_ERROR: begin
                    if (rx_data == CHAR_CR) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    shadow_d = '0;
                    count_d  = '0;
                    state_d  = ST_IDLE;
                end
            endcase
        end
    end

    // Free-running scan prescaler and digit index
    always_comb begin
        presc_d = presc_q + PRE_W'(1);
        index_d = index_q;
        if (presc_q == PRE_W'(SCAN_DIV - 1)) begin
            presc_d = '0;
            if (index_q == IDX_W'(NUM_DIGITS - 1)) begin
                index_d = '0;
            end else begin
                index_d = index_q + IDX_W'(1);
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shadow_q    <= '0;
            count_q     <= '0;
            digit_val_q <= '0;
            commit_q    <= 1'b0;
            err_q       <= 1'b0;
            presc_q     <= '0;
            index_q     <= '0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            count_q     <= count_d;
            digit_val_q <= digit_val_d;
            commit_q    <= commit_d;
            err_q       <= err_d;
            presc_q     <= presc_d;
            index_q     <= index_d;
        end
    end

    // Digit decode straight off the registers so a commit shows immediately
    always_comb begin
        scan_sel    = '0;
        scan_nibble = 4'h0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (index_q == IDX_W'(i)) begin
                scan_sel[i] = 1'b1;
                scan_nibble = digit_val_q[4*i +: 4];
            end
        end
    end

    assign digit_val = digit_val_q;
    assign commit    = commit_q;
    assign err       = err_q;

endmodule

// File: tb/tb_uart_hex_display_ctrl.sv
// Directed bench for uart_hex_display_ctrl (NUM_DIGITS=4, SCAN_DIV=4).
module tb_uart_hex_display_ctrl;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned SCAN_DIV   = 4;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  conv_ascii;
    logic [3:0]  conv_nibble;
    logic [15:0] digit_val;
    logic        commit;
    logic        err;
    logic [3:0]  scan_sel;
    logic [3:0]  scan_nibble;

    int n_checks;
    int n_fail;
    int commit_cnt;
    int err_cnt;

    uart_hex_display_ctrl #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .conv_ascii  (conv_ascii),
        .conv_nibble (conv_nibble),
        .digit_val   (digit_val),
        .commit      (commit),
        .err         (err),
        .scan_sel    (scan_sel),
        .scan_nibble (scan_nibble)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External converter: uppercase hex and (deliberately) lowercase too
    always_comb begin
        if (conv_ascii >= 8'h30 && conv_ascii <= 8'h39)
            conv_nibble = 4'(conv_ascii - 8'h30);
        else if (conv_ascii >= 8'h41 && conv_ascii <= 8'h46)
            conv_nibble = 4'(conv_ascii - 8'h37);
        else if (conv_ascii >= 8'h61 && conv_ascii <= 8'h66)
            conv_nibble = 4'(conv_ascii - 8'h57);
        else
            conv_nibble = 4'h0;
    end

    // Pulse counters; a stuck pulse counts more than once
    always @(posedge clk) begin
        if (rst_n && commit) commit_cnt <= commit_cnt + 1;
        if (rst_n && err)    err_cnt    <= err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic put(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_line(input string tag, input int c0, input int e0,
                              input int dc, input int de, input logic [15:0] val);
        check({tag, "_commits"}, 32'(commit_cnt - c0), 32'(dc));
        check({tag, "_errs"},    32'(err_cnt - e0),    32'(de));
        check({tag, "_value"},   32'(digit_val),       32'(val));
    endtask

    initial begin
        int c0;
        int e0;
        int waited;
        logic [3:0] prev_sel;
        logic [3:0] nib_tab [4];
        n_checks   = 0;
        n_fail     = 0;
        commit_cnt = 0;
        err_cnt    = 0;
        rst_n      = 1'b0;
        rx_valid   = 1'b0;
        rx_data    = 8'h00;
        nib_tab    = '{4'hF, 4'h3, 4'hA, 4'h1};

        // rx traffic during reset must be ignored
        repeat (2) @(negedge clk);
        rx_data  = 8'h35;
        rx_valid = 1'b1;
        @(negedge clk);
        check("conv_ascii_follows", 32'(conv_ascii), 32'h35);
        rx_valid = 1'b0;
        check("rst_digit_val",   32'(digit_val),   32'h0);
        check("rst_commit",      32'(commit),      32'h0);
        check("rst_err",         32'(err),         32'h0);
        check("rst_scan_sel",    32'(scan_sel),    32'h1);
        check("rst_scan_nibble", 32'(scan_nibble), 32'h0);
        rst_n = 1'b1;

        // Reset-time byte must not become a pending digit
        c0 = commit_cnt; e0 = err_cnt;
        put(8'h0D); idle(2);
        check_line("after_rst_cr", c0, e0, 0, 0, 16'h0000);

        // Full line, back-to-back
        c0 = commit_cnt; e0 = err_cnt;
        put("1"); put("A"); put("3"); put("F"); put(8'h0D); idle(2);
        check_line("line_1A3F", c0, e0, 1, 0, 16'h1A3F);

        // Scan sequence: lock onto 1000 -> 0001, then step every 4 cycles
        prev_sel = scan_sel;
        waited   = 0;
        @(negedge clk);
        while (!(prev_sel == 4'b1000 && scan_sel == 4'b0001) && waited < 40) begin
            prev_sel = scan_sel;
            @(negedge clk);
            waited++;
        end
        check("scan_lock_timeout", 32'(waited < 40), 32'h1);
        for (int k = 0; k <= 16; k += 4) begin
            check($sformatf("scan_sel_%0d", k),    32'(scan_sel),    32'(4'b0001 << ((k / 4) % 4)));
            check($sformatf("scan_nibble_%0d", k), 32'(scan_nibble), 32'(nib_tab[(k / 4) % 4]));
            if (k != 16) repeat (4) @(negedge clk);
        end

        // Short line zero-extends; lone CR is a no-op
        c0 = commit_cnt; e0 = err_cnt;
        put("7"); put("B"); put(8'h0D); idle(2);
        check_line("line_7B", c0, e0, 1, 0, 16'h007B);
        c0 = commit_cnt; e0 = err_cnt;
        put(8'h0D); idle(2);
        check_line("lone_cr", c0, e0, 0, 0, 16'h007B);

        // Overlong line keeps the last four digits
        c0 = commit_cnt; e0 = err_cnt;
        put("1"); put("2"); put("3"); put("4"); put("5"); put(8'h0D); idle(2);
        check_line("line_12345", c0, e0, 1, 0, 16'h2345);

        // Invalid char discards the line, single err pulse
        c0 = commit_cnt; e0 = err_cnt;
        put("1"); put("g"); put("2"); put(8'h0D); idle(2);
        check_line("line_bad_g", c0, e0, 0, 1, 16'h2345);
        c0 = commit_cnt; e0 = err_cnt;
        put("9"); put(8'h0D); idle(2);
        check_line("line_9", c0, e0, 1, 0, 16'h0009);

        // LF ignored mid-line
        c0 = commit_cnt; e0 = err_cnt;
        put("4"); put(8'h0A); put("2"); put(8'h0D); idle(2);
        check_line("line_lf", c0, e0, 1, 0, 16'h0042);

        // Lowercase hex is invalid
        c0 = commit_cnt; e0 = err_cnt;
        put("a"); put("b"); put(8'h0D); idle(2);
        check_line("line_lower", c0, e0, 0, 1, 16'h0042);

        // Reset mid-line drops pending digits
        put("5"); put("6"); idle(0);
        rst_n = 1'b0;
        #1;
        check("midrst_digit_val",   32'(digit_val),   32'h0);
        check("midrst_commit",      32'(commit),      32'h0);
        check("midrst_err",         32'(err),         32'h0);
        check("midrst_scan_sel",    32'(scan_sel),    32'h1);
        check("midrst_scan_nibble", 32'(scan_nibble), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        c0 = commit_cnt; e0 = err_cnt;
        put(8'h0D); idle(2);
        check_line("midrst_cr", c0, e0, 0, 0, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_hex_display_ctrl.md
UART_HEX_DISPLAY_CTRL -- requirements
Module: uart_hex_display_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of hex digits buffered and scanned (range 1-8).
REQ-002 Parameter SCAN_DIV, default 50000: clk cycles per scan digit slot (minimum 2).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 rx_data  input  8  received byte from the UART receiver.
REQ-006 rx_valid  input  1  one-cycle strobe qualifying rx_data; no backpressure.
REQ-007 conv_ascii  output  8  byte presented to the external ASCII-to-nibble converter.
REQ-008 conv_nibble  input  4  converter result for conv_ascii, same cycle (combinational path).
REQ-009 digit_val  output  4*NUM_DIGITS  committed display value; digit 0 in bits [3:0].
REQ-010 commit  output  1  one-cycle pulse when digit_val is updated.
REQ-011 err  output  1  one-cycle pulse on the first invalid character of a line.
REQ-012 scan_sel  output  NUM_DIGITS  one-hot, active-high digit enable.
REQ-013 scan_nibble  output  4  nibble of digit_val for the enabled digit.

Function
REQ-014 conv_ascii SHALL equal rx_data continuously; conv_nibble SHALL be sampled only when rx_valid=1.
REQ-015 Valid hex chars SHALL be 0x30-0x39 and 0x41-0x46 only; lowercase is invalid.
REQ-016 CR (0x0D) SHALL be the line terminator; LF (0x0A) SHALL be ignored in every state.
REQ-017 FSM states SHALL be IDLE (no digits pending), COLLECT (>=1 digit pending), ERROR (discarding line).
REQ-018 IDLE/COLLECT + valid hex: shadow <= {shadow[4*NUM_DIGITS-5:0], conv_nibble}; count saturates at NUM_DIGITS; next state COLLECT.
REQ-019 More than NUM_DIGITS hex chars SHALL drop the oldest digit; the last NUM_DIGITS are kept.
REQ-020 COLLECT + CR: digit_val <= shadow, commit=1 next cycle, shadow and count cleared, next state IDLE.
REQ-021 IDLE + CR: no commit, digit_val unchanged, stay IDLE.
REQ-022 IDLE/COLLECT + any other byte: err=1 next cycle, shadow and count cleared, next state ERROR.
REQ-023 ERROR: all bytes except CR discarded with no further err; CR returns to IDLE with no commit.
REQ-024 Latency: rx_valid at edge N SHALL produce commit/err/digit_val visible after edge N+1; back-to-back rx_valid every cycle SHALL be supported.
REQ-025 Fewer than NUM_DIGITS digits SHALL be zero-extended in the upper digits (first-received char most significant).
REQ-026 Scan prescaler SHALL count 0..SCAN_DIV-1 and wrap; on wrap, digit index advances mod NUM_DIGITS.
REQ-027 scan_sel = 1 << index; scan_nibble = digit_val[4*index +: 4], reflecting a commit within the same cycle digit_val changes.
REQ-028 Scanning SHALL run freely, independent of FSM state and rx traffic.

Reset
REQ-029 rst_n=0 SHALL immediately force: state IDLE, shadow=0, count=0, digit_val=0, commit=0, err=0, prescaler=0, index=0, scan_sel=1 (bit 0), scan_nibble=0.
REQ-030 Reset mid-line SHALL discard pending digits; the first byte after release starts a new line.
REQ-031 rx_valid during reset SHALL be ignored.

Verification
REQ-032 NUM_DIGITS=4: send '1','A','3','F',CR -> one commit pulse, digit_val=0x1A3F, err never high.
REQ-033 Send '7','B',CR -> digit_val=0x007B; then CR alone -> no commit, digit_val stays 0x007B.
REQ-034 Send '1','2','3','4','5',CR -> digit_val=0x2345 (oldest dropped).
REQ-035 Send '1','g','2',CR then '9',CR -> err pulses once at 'g', no commit for the first line; second line commits digit_val=0x0009.
REQ-036 SCAN_DIV=4, digit_val=0x1A3F: scan_sel steps 0001,0010,0100,1000,0001 every 4 cycles with scan_nibble F,3,A,1,F.
REQ-037 Assert rst_n=0 after '5','6' then release and send CR -> no commit, all outputs at reset values, scan_sel=0001.
